cpa_mult_ctrl: RTL
==================

CPA_MULT_CTRL -- requirements
Module: cpa_mult_ctrl

Interface
REQ-001 Parameters: none; operand width fixed at 4 bits, matching the 4-bit CPA datapath.
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 START  input  1  request a multiply; sampled only in IDLE.
REQ-005 A  input  4  multiplicand, unsigned; sampled when START accepted.
REQ-006 B  input  4  multiplier, unsigned; sampled when START accepted.
REQ-007 ADD_A  output  4  operand A to external 4-bit CPA.
REQ-008 ADD_B  output  4  operand B to external 4-bit CPA.
REQ-009 ADD_CI  output  1  carry-in to external CPA.
REQ-010 ADD_S  input  4  sum from external CPA, combinational, same cycle.
REQ-011 ADD_CO  input  1  carry-out from external CPA, same cycle.
REQ-012 P  output  8  registered product, unsigned.
REQ-013 BUSY  output  1  high while a multiply is in progress (CALC or DONE state).
REQ-014 DONE  output  1  one-cycle pulse: P holds a new valid result.

Function
REQ-015 Internal registers: MCAND[3:0], MPLR[3:0], ACC[3:0], CNT[1:0], state.
REQ-016 States: IDLE, CALC, DONE; encoding free, no other reachable states.
REQ-017 IDLE, START=1: MCAND<=A, MPLR<=B, ACC<=0, CNT<=0, next CALC.
REQ-018 IDLE, START=0: all registers hold, stay IDLE.
REQ-019 CALC: ADD_A=ACC; ADD_B=MCAND if MPLR[0]=1, else 4'h0; ADD_CI=0.
REQ-020 CALC, each cycle: {ACC,MPLR} <= {ADD_CO, ADD_S, MPLR[3:1]}, i.e. 9-bit sum shifted right by one.
REQ-021 CALC: CNT increments each cycle; when CNT=3, next state DONE, else stay CALC.
REQ-022 Exactly 4 CALC cycles per multiply, independent of operand values (no early exit on zero).
REQ-023 Transition CALC->DONE: P<={ACC_next, MPLR_next} captured on the same edge.
REQ-024 DONE: DONE=1, BUSY=1 for exactly one cycle, then IDLE unconditionally.
REQ-025 IDLE and DONE: ADD_A=0, ADD_B=0, ADD_CI=0.
REQ-026 Latency: START accepted on edge k -> CALC cycles k+1..k+4 -> DONE high in cycle k+5 with P valid.
REQ-027 Throughput: START held high re-accepted in the IDLE cycle after DONE; one result per 6 cycles.
REQ-028 START during CALC or DONE: ignored; A/B changes during CALC have no effect.
REQ-029 P holds last result through IDLE and next multiply until the next CALC->DONE edge.
REQ-030 Arithmetic: P = A*B exactly, 0..225; no overflow possible in 8 bits.
REQ-031 DONE never high in IDLE or CALC; BUSY never high in IDLE.

Reset
REQ-032 RST=1 at an edge: state<=IDLE, P<=0, ACC<=0, MPLR<=0, MCAND<=0, CNT<=0.
REQ-033 Outputs during and after reset: BUSY=0, DONE=0, P=8'h00, ADD_A=ADD_B=0, ADD_CI=0.
REQ-034 RST overrides START in the same cycle; no request accepted while RST=1.
REQ-035 RST mid-operation (CALC or DONE) aborts; no DONE pulse for aborted operation; P cleared.

Verification
REQ-036 A=2, B=7, START one cycle -> BUSY high 5 cycles, DONE pulse cycle k+5, P=8'd14.
REQ-037 A=15, B=15 -> P=8'd225; ADD_CO=1 observed in at least one CALC cycle.
REQ-038 A=0, B=9 then A=9, B=0 -> both P=8'd0, still 4 CALC cycles each.
REQ-039 START held high, A=3,B=5 -> DONE at k+5 P=15, next DONE at k+11 with new operands' product.
REQ-040 START pulsed during CALC with different A/B -> ignored, P equals product of original operands.
REQ-041 RST asserted in second CALC cycle of 6*6 -> next cycle BUSY=0, P=0, no DONE; new START gives correct product.

Source files
------------

// File: rtl/cpa_mult_ctrl.sv
// Shift-and-add 4x4 unsigned multiplier sequencer that drives an external 4-bit CPA.
// It issues one add per CALC cycle, always four of them, and registers the 8-bit product.
//
// state   | meaning
// --------+-------------------------------------------------------------
// st_idle | waiting for start; the product register holds the last result
// st_calc | four add/shift steps using the external adder
// st_done | one-cycle result strobe, then back to idle
module cpa_mult_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    output logic       add_ci,
    input  logic [3:0] add_s,
    input  logic       add_co,
    output logic [7:0] p,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_calc = 2'd1,
        st_done = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] mcand, mcand_nxt;
    logic [3:0] mplr, mplr_nxt;
    logic [3:0] acc, acc_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic [7:0] p_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= st_idle;
            mcand <= 4'h0;
            mplr  <= 4'h0;
            acc   <= 4'h0;
            cnt   <= 2'd0;
            p     <= 8'h00;
        end else begin
            state <= state_nxt;
            mcand <= mcand_nxt;
            mplr  <= mplr_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            p     <= p_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mcand_nxt = mcand;
        mplr_nxt  = mplr;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        p_nxt     = p;
        add_a     = 4'h0;
        add_b     = 4'h0;
        add_ci    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        unique case (state)
            st_idle: begin
                if (start) begin
                    mcand_nxt = a;
                    mplr_nxt  = b;
                    acc_nxt   = 4'h0;
                    cnt_nxt   = 2'd0;
                    state_nxt = st_calc;
                end
            end
            st_calc: begin
                busy  = 1'b1;
                add_a = acc;
                add_b = mplr[0] ? mcand : 4'h0;
                // The 9-bit sum {co, s, mplr} shifted right by one: the multiplier
                // lsb just consumed drops out and the sum lsb moves into mplr.
                {acc_nxt, mplr_nxt} = {add_co, add_s, mplr[3:1]};
                cnt_nxt = cnt + 2'd1;
                if (cnt == 2'd3) begin
                    p_nxt     = {acc_nxt, mplr_nxt};
                    state_nxt = st_done;
                end
            end
            st_done: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = st_idle;
            end
            default: begin
                state_nxt = st_idle;
            end
        endcase
    end

    a_done_implies_busy: assert property (@(posedge clk) disable iff (rst) done |-> busy);
    a_legal_state: assert property (@(posedge clk) disable iff (rst)
        (state == st_idle) || (state == st_calc) || (state == st_done));

endmodule
